// File: rtl/fetch_unit.sv
// fetch_unit: PC / fetch-control stage in front of the 32x16 instruction memory.
// Ports: clk, rst_n, start, step_mode, step, imem_addr, imem_data, branch_taken,
//        instr, instr_valid, pc, running, halted, retired.
module fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch_taken,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] OP_BR   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            state;
  logic [2:0]        op;
  logic [ADDR_W-1:0] tgt;
  logic              commit;
  logic              is_halt;
  logic              take_br;
  logic              cnt_max;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;

  assign imem_addr = pc;
  assign instr     = imem_data;

  assign op  = imem_data[INSTR_W-1 -: 3];
  assign tgt = imem_data[INSTR_W-4 -: ADDR_W];

  // step_mode is sampled combinationally so a mode change
  // takes effect in the same cycle.
  assign commit = (state == ACTIVE)
                & (step_mode ? step : 1'b1);
  assign instr_valid = commit;

  assign is_halt = (op == OP_HALT);
  assign take_br = (op == OP_BR) & branch_taken;
  assign cnt_max = &retired;
  assign pc_inc  = pc + PC_ONE;

  always_comb begin
    pc_nxt = pc_inc;
    unique case (1'b1)
      take_br: pc_nxt = tgt;
      default: pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      retired <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= ACTIVE;
            pc      <= '0;
            retired <= '0;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (commit) begin
            if (!cnt_max) begin
              retired <= retired + CNT_ONE;
            end
            // halt retires as a no-op and freezes pc on itself
            if (is_halt) begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
            end else begin
              pc <= pc_nxt;
            end
          end
        end
        HALTED: begin
          if (start) begin
            state   <= ACTIVE;
            pc      <= '0;
            retired <= '0;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule
